fixed_to_float_unit: RTL and testbench

FIXED_TO_FLOAT_UNIT -- requirements
Module: fixed_to_float_unit

---
 rtl/fixed_float_pkg.sv | 26 ++
 rtl/lod_encoder.sv | 26 ++
 rtl/fixed_to_float_unit.sv | 153 +++++++++++++++
 tb/tb_fixed_to_float_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fixed_float_pkg.sv
// Shared types and parameter derivations for the fixed-point to IEEE-754 converter.
// Holds the FSM state encoding and the exponent-bias / output-width helpers.
package fixed_float_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int calc_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int calc_fw(input int ew, input int mw);
        return 1 + ew + mw;
    endfunction

    // Width of a bit-position index; kept at least 1 so single-bit vectors still elaborate.
    function automatic int calc_pw(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lod_encoder.sv
// Leading-one detector: reports the index of the most significant set bit.
// valid is low (and pos is 0) when the input is all zeros.
module lod_encoder
    import fixed_float_pkg::*;
#(
    parameter int W  = 32,
    parameter int PW = calc_pw(W)
) (
    input  logic [W-1:0]  vec,
    output logic [PW-1:0] pos,
    output logic          valid
);

    // Ascending scan: the last set bit seen wins, i.e. the most significant one.
    always_comb begin
        pos   = '0;
        valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                pos   = PW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_to_float_unit.sv
// Multi-cycle two's-complement fixed-point to IEEE-754 converter.
// Pipeline of states IDLE -> ABS -> NORM -> ROUND -> DONE with fixed latency.
module fixed_to_float_unit
    import fixed_float_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 26,
    parameter int EW   = 8,
    parameter int MW   = 23
) (
    input  logic                         CLK,
    input  logic                         RST_FF,
    input  logic                         BEGIN,
    input  logic [W-1:0]                 DIN,
    input  logic                         RND_MODE,
    output logic [calc_fw(EW, MW)-1:0]   DOUT,
    output logic                         ACK,
    output logic                         BUSY,
    output logic                         ZERO
);

    localparam int FW      = calc_fw(EW, MW);
    localparam int BIAS    = calc_bias(EW);
    localparam int PW      = calc_pw(W);
    localparam int EXP_OFF = BIAS - FRAC;

    // The exponent range must stay strictly inside the normal range for every input.
    generate
        if ((EXP_OFF < 1) || (W - 1 - FRAC + BIAS > (1 << EW) - 2) || (W < 3)) begin : g_bad_params
            $error("fixed_to_float_unit: parameters allow denormal/inf exponents or W < 3");
        end
    endgenerate

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    din_reg;
    logic            rnd_reg;
    logic            sign_reg;
    logic [W-1:0]    mag_reg;
    logic            zero_reg;
    logic [W-1:0]    aligned_reg;
    logic [PW-1:0]   pos_reg;
    logic [FW-1:0]   dout_reg;

    logic [W-1:0]    mag_next;
    logic [PW-1:0]   lod_pos;
    logic            lod_valid;
    logic [PW-1:0]   shift_amt;
    logic [W-1:0]    aligned_next;
    logic [W+MW-1:0] ext;
    logic [MW-1:0]   mant_raw;
    logic            guard_bit;
    logic            sticky_bit;
    logic            round_inc;
    logic [MW:0]     mant_sum;
    logic [EW-1:0]   exp_base;
    logic [EW-1:0]   exp_final;
    logic [FW-1:0]   dout_next;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (BEGIN) state_next = ABS;
            ABS:     state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (!BEGIN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- datapath combinational ----------------
    // Negating the most-negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign mag_next = din_reg[W-1] ? (~din_reg + 1'b1) : din_reg;

    lod_encoder #(
        .W  (W),
        .PW (PW)
    ) u_lod (
        .vec   (mag_reg),
        .pos   (lod_pos),
        .valid (lod_valid)
    );

    assign shift_amt    = PW'(W - 1) - lod_pos;
    assign aligned_next = lod_valid ? (mag_reg << shift_amt) : '0;

    // Appending MW zero bits makes the p<MW zero-padding case fall out naturally.
    assign ext        = {aligned_reg, {MW{1'b0}}};
    assign mant_raw   = ext[W+MW-2 -: MW];
    assign guard_bit  = ext[W-2];
    assign sticky_bit = |ext[W-3:0];
    assign round_inc  = rnd_reg & guard_bit & (sticky_bit | mant_raw[0]);
    assign mant_sum   = {1'b0, mant_raw} + {{MW{1'b0}}, round_inc};

    // A rounding carry leaves mant_sum[MW-1:0] at zero and bumps the exponent.
    assign exp_base  = EW'(EXP_OFF) + EW'(pos_reg);
    assign exp_final = exp_base + {{(EW-1){1'b0}}, mant_sum[MW]};
    assign dout_next = zero_reg ? '0 : {sign_reg, exp_final, mant_sum[MW-1:0]};

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            din_reg     <= '0;
            rnd_reg     <= 1'b0;
            sign_reg    <= 1'b0;
            mag_reg     <= '0;
            zero_reg    <= 1'b0;
            aligned_reg <= '0;
            pos_reg     <= '0;
            dout_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (BEGIN) begin
                        din_reg <= DIN;
                        rnd_reg <= RND_MODE;
                    end
                end
                ABS: begin
                    sign_reg <= din_reg[W-1];
                    mag_reg  <= mag_next;
                    zero_reg <= (din_reg == '0);
                end
                NORM: begin
                    aligned_reg <= aligned_next;
                    pos_reg     <= lod_pos;
                end
                ROUND: begin
                    dout_reg <= dout_next;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign DOUT = dout_reg;
    assign ACK  = (state_reg == DONE);
    assign BUSY = (state_reg != IDLE);
    assign ZERO = (state_reg == DONE) && zero_reg;

endmodule

// File: tb/tb_fixed_to_float_unit.sv
// Self-checking bench for fixed_to_float_unit (W=32, FRAC=26, EW=8, MW=23).
// Expected floats come from an exact double conversion narrowed to single precision.
module tb_fixed_to_float_unit;

    logic        CLK = 1'b0;
    logic        RST_FF;
    logic        BEGIN;
    logic [31:0] DIN;
    logic        RND_MODE;
    logic [31:0] DOUT;
    logic        ACK;
    logic        BUSY;
    logic        ZERO;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_to_float_unit #(
        .W    (32),
        .FRAC (26),
        .EW   (8),
        .MW   (23)
    ) dut (
        .CLK      (CLK),
        .RST_FF   (RST_FF),
        .BEGIN    (BEGIN),
        .DIN      (DIN),
        .RND_MODE (RND_MODE),
        .DOUT     (DOUT),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .ZERO     (ZERO)
    );

    always #5 CLK = ~CLK;

    // Value is DIN / 2^26 as an exact double, then narrowed to binary32.
    function automatic logic [31:0] ref_float(input logic [31:0] d, input logic rm);
        real         r;
        logic [63:0] b;
        logic [10:0] e11;
        logic [51:0] m52;
        logic [23:0] m24;
        int          e8;
        logic [7:0]  ev;
        r = $itor($signed(d)) / 67108864.0;
        if (r == 0.0) return 32'h0000_0000;
        b   = $realtobits(r);
        e11 = b[62:52];
        m52 = b[51:0];
        e8  = int'(e11) - 1023 + 127;
        m24 = {1'b0, m52[51:29]};
        if (rm && m52[28] && ((|m52[27:0]) || m52[29]))
            m24 = m24 + 24'd1;
        if (m24[23]) begin
            m24 = '0;
            e8  = e8 + 1;
        end
        ev = 8'(e8);
        return {b[63], ev, m24[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One conversion; hold keeps BEGIN high to exercise the DONE hold behaviour.
    task automatic run_conv(input string tag, input logic [31:0] d, input logic rm, input logic hold);
        logic [31:0] exp_v;
        exp_v = ref_float(d, rm);
        @(negedge CLK);
        BEGIN    = 1'b1;
        DIN      = d;
        RND_MODE = rm;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #1;
            if (k == 1) begin
                if (!hold) BEGIN = 1'b0;
                DIN      = $urandom;
                RND_MODE = ~rm;
            end
            check({tag, " ack"}, {31'd0, ACK}, {31'd0, (k == 4)});
            check({tag, " busy"}, {31'd0, BUSY}, 32'd1);
        end
        check({tag, " dout"}, DOUT, exp_v);
        check({tag, " zero"}, {31'd0, ZERO}, {31'd0, (exp_v == 32'd0)});
        if (hold) begin
            repeat (2) @(posedge CLK);
            #1;
            check({tag, " hold ack"}, {31'd0, ACK}, 32'd1);
            check({tag, " hold dout"}, DOUT, exp_v);
            @(negedge CLK);
            BEGIN = 1'b0;
        end
        @(posedge CLK);
        #1;
        check({tag, " idle ack"}, {31'd0, ACK}, 32'd0);
        check({tag, " idle busy"}, {31'd0, BUSY}, 32'd0);
        $display("conv %s din=%h rm=%0d hold=%0d dout=%h exp=%h", tag, d, rm, hold, DOUT, exp_v);
    endtask

    initial begin
        logic [31:0] d;
        RST_FF   = 1'b1;
        BEGIN    = 1'b0;
        DIN      = '0;
        RND_MODE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset dout", DOUT, 32'd0);
        check("reset ack",  {31'd0, ACK},  32'd0);
        check("reset busy", {31'd0, BUSY}, 32'd0);
        check("reset zero", {31'd0, ZERO}, 32'd0);
        @(negedge CLK);
        RST_FF = 1'b0;

        // Directed cases with hand-derived constants.
        run_conv("one",    32'h0400_0000, 1'b1, 1'b0);
        check("one const", DOUT, 32'h3F80_0000);
        run_conv("m1p5",   32'hFA00_0000, 1'b1, 1'b0);
        check("m1p5 const", DOUT, 32'hBFC0_0000);
        run_conv("m32",    32'h8000_0000, 1'b0, 1'b0);
        check("m32 const", DOUT, 32'hC200_0000);
        run_conv("max rne", 32'h7FFF_FFFF, 1'b1, 1'b0);
        check("max rne const", DOUT, 32'h4200_0000);
        run_conv("max trunc", 32'h7FFF_FFFF, 1'b0, 1'b0);
        check("max trunc const", DOUT, 32'h41FF_FFFF);
        run_conv("zero hold", 32'h0000_0000, 1'b1, 1'b1);
        run_conv("tiny", 32'h0000_0001, 1'b1, 1'b0);
        check("tiny const", DOUT, 32'h3280_0000);
        run_conv("m1p5 again", 32'hFA00_0000, 1'b0, 1'b0);

        // Asynchronous reset while the conversion sits in NORM.
        @(negedge CLK);
        BEGIN = 1'b1;
        DIN   = 32'h1234_5678;
        @(posedge CLK);
        #1;
        BEGIN = 1'b0;
        @(posedge CLK);
        #1;
        RST_FF = 1'b1;
        #1;
        check("abort dout", DOUT, 32'd0);
        check("abort ack",  {31'd0, ACK},  32'd0);
        check("abort busy", {31'd0, BUSY}, 32'd0);
        check("abort zero", {31'd0, ZERO}, 32'd0);
        @(negedge CLK);
        RST_FF = 1'b0;
        run_conv("post reset", 32'h0400_0000, 1'b1, 1'b0);
        check("post reset const", DOUT, 32'h3F80_0000);

        // Random operands across the whole magnitude range.
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            if (i % 2 == 1) d = d >> $urandom_range(0, 31);
            if (i % 5 == 4) d = -d;
            run_conv($sformatf("rnd%0d", i), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
